// File: rtl/fp_alu_scheduler.sv
// fp_alu_scheduler: arbitrates two requesters onto one combinational FP ALU.
// Requesters are granted round-robin on ties. The operation is held on the ALU for a
// per-opcode number of cycles. The result is then captured and offered on a
// valid/ready response port, and exception flags accumulate into a sticky register.
module fp_alu_scheduler #(
   parameter int ADD_LAT = 2,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic [5:0]  alu_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic [5:0]  rsp_flags,
   output logic [5:0]  sticky_flags,
   input  logic        clr_flags,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_MUL = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4;

   // A configured latency of zero still needs one EXEC cycle to sample the ALU.
   function automatic logic [31:0] clamp_lat(input int l);
      logic [31:0] v;
      v = l;
      return (l < 1) ? 32'd1 : v;
   endfunction

   function automatic logic [31:0] latency(input logic [2:0] op);
      case (op)
         OP_ADD, OP_SUB: return clamp_lat(ADD_LAT);
         OP_MUL:         return clamp_lat(MUL_LAT);
         OP_DIV:         return clamp_lat(DIV_LAT);
         default:        return 32'd1;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [31:0] cnt_q;
   logic        last_grant_q;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic        id_q;
   logic        rsp_id_q;
   logic [31:0] rsp_result_q;
   logic [5:0]  rsp_flags_q;
   logic [5:0]  sticky_q, sticky_d;
   logic        grant_v_s;
   logic        grant_id_s;
   logic        capture_s;

   // Next-state and arbitration: tie goes to the requester not granted last time.
   always_comb begin
      state_d    = state_q;
      grant_v_s  = 1'b0;
      grant_id_s = 1'b0;
      capture_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_valid && req1_valid) begin
               grant_v_s  = 1'b1;
               grant_id_s = ~last_grant_q;
            end else if (req0_valid) begin
               grant_v_s  = 1'b1;
               grant_id_s = 1'b0;
            end else if (req1_valid) begin
               grant_v_s  = 1'b1;
               grant_id_s = 1'b1;
            end else begin
               grant_v_s  = 1'b0;
            end
            if (grant_v_s) begin
               state_d = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            if (cnt_q == 32'd0) begin
               capture_s = 1'b1;
               state_d   = RESP;
            end else begin
               state_d   = EXEC;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sticky flags: a clear coinciding with a capture keeps only the new flags.
   always_comb begin
      sticky_d = sticky_q;
      if (capture_s) begin
         sticky_d = clr_flags ? alu_flags : (sticky_q | alu_flags);
      end else if (clr_flags) begin
         sticky_d = 6'd0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // State, operation latch, latency counter and response capture registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 32'd0;
         last_grant_q <= 1'b1;
         op_q         <= OP_NOP;
         a_q          <= 32'd0;
         b_q          <= 32'd0;
         id_q         <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= 32'd0;
         rsp_flags_q  <= 6'd0;
         sticky_q     <= 6'd0;
      end else begin
         state_q  <= state_d;
         sticky_q <= sticky_d;
         if (state_q == IDLE && grant_v_s) begin
            op_q         <= grant_id_s ? req1_op : req0_op;
            a_q          <= grant_id_s ? req1_a : req0_a;
            b_q          <= grant_id_s ? req1_b : req0_b;
            id_q         <= grant_id_s;
            last_grant_q <= grant_id_s;
            cnt_q        <= latency(grant_id_s ? req1_op : req0_op) - 32'd1;
         end else if (state_q == EXEC) begin
            if (capture_s) begin
               rsp_id_q     <= id_q;
               rsp_result_q <= alu_result;
               rsp_flags_q  <= alu_flags;
            end else begin
               cnt_q <= cnt_q - 32'd1;
            end
         end
      end
   end

   assign req0_ready   = grant_v_s & ~grant_id_s;
   assign req1_ready   = grant_v_s & grant_id_s;
   assign alu_in1      = (state_q == EXEC) ? a_q : 32'd0;
   assign alu_in2      = (state_q == EXEC) ? b_q : 32'd0;
   assign alu_op       = (state_q == EXEC) ? op_q : OP_NOP;
   assign rsp_valid    = (state_q == RESP);
   assign rsp_id       = rsp_id_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_flags    = rsp_flags_q;
   assign sticky_flags = sticky_q;
   assign busy         = (state_q == EXEC) || (state_q == RESP);

endmodule

// File: tb/tb_fp_alu_scheduler.sv
// Directed testbench for fp_alu_scheduler with a small combinational ALU stand-in.
// A second instance built with ADD_LAT=0 covers the clamped-latency case.
module tb_fp_alu_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [2:0]  req0_op, req1_op, alu_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_in1, alu_in2, alu_result, rsp_result;
   logic [5:0]  alu_flags, rsp_flags, sticky_flags;
   logic        rsp_valid, rsp_ready, rsp_id, clr_flags, busy;

   logic        z_req0_valid, z_req0_ready, z_req1_ready;
   logic [2:0]  z_req0_op, z_alu_op;
   logic [31:0] z_req0_a, z_req0_b, z_alu_in1, z_alu_in2, z_alu_result, z_rsp_result;
   logic [5:0]  z_alu_flags, z_rsp_flags, z_sticky;
   logic        z_rsp_valid, z_rsp_id, z_busy;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] held_res;

   always #5 clk = ~clk;

   // ALU stand-in: 1.0+2.0 gives 3.0, x/0 raises division_by_zero, RND raises inexact.
   function automatic logic [37:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      logic [5:0]  f;
      r = a ^ b ^ {29'd0, op};
      f = 6'd0;
      if (op == 3'd1 && a == 32'h3F800000 && b == 32'h40000000) r = 32'h40400000;
      if (op == 3'd4 && b == 32'd0) f = 6'b100000;
      if (op == 3'd5) f = 6'b000100;
      return {f, r};
   endfunction

   assign {alu_flags, alu_result}     = alu_model(alu_op, alu_in1, alu_in2);
   assign {z_alu_flags, z_alu_result} = alu_model(z_alu_op, z_alu_in1, z_alu_in2);

   fp_alu_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .sticky_flags(sticky_flags), .clr_flags(clr_flags), .busy(busy)
   );

   fp_alu_scheduler #(.ADD_LAT(0)) dut_z (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(z_req0_valid), .req0_ready(z_req0_ready), .req0_op(z_req0_op),
      .req0_a(z_req0_a), .req0_b(z_req0_b),
      .req1_valid(1'b0), .req1_ready(z_req1_ready), .req1_op(3'd0),
      .req1_a(32'd0), .req1_b(32'd0),
      .alu_in1(z_alu_in1), .alu_in2(z_alu_in2), .alu_op(z_alu_op),
      .alu_result(z_alu_result), .alu_flags(z_alu_flags),
      .rsp_valid(z_rsp_valid), .rsp_ready(1'b1), .rsp_id(z_rsp_id),
      .rsp_result(z_rsp_result), .rsp_flags(z_rsp_flags),
      .sticky_flags(z_sticky), .clr_flags(1'b0), .busy(z_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b1; clr_flags = 1'b0;
      req0_valid = 1'b0; req0_op = 3'd0; req0_a = 32'd0; req0_b = 32'd0;
      req1_valid = 1'b0; req1_op = 3'd0; req1_a = 32'd0; req1_b = 32'd0;
      z_req0_valid = 1'b0; z_req0_op = 3'd0; z_req0_a = 32'd0; z_req0_b = 32'd0;
      tick(); tick();
      rst_n = 1'b1;
      #1;
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_alu_op", {29'd0, alu_op}, 32'd0);
      check("rst_alu_in1", alu_in1, 32'd0);
      check("rst_sticky", {26'd0, sticky_flags}, 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);

      // ADD 1.0 + 2.0 from requester 0
      req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
      #1;
      check("add_ready0", {31'd0, req0_ready}, 32'd1);
      tick(); req0_valid = 1'b0; #1;
      check("add_exec1_op", {29'd0, alu_op}, 32'd1);
      check("add_exec1_in1", alu_in1, 32'h3F800000);
      check("add_exec1_in2", alu_in2, 32'h40000000);
      check("add_exec1_busy", {31'd0, busy}, 32'd1);
      tick();
      check("add_exec2_op", {29'd0, alu_op}, 32'd1);
      check("add_exec2_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("add_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("add_rsp_result", rsp_result, 32'h40400000);
      check("add_rsp_flags", {26'd0, rsp_flags}, 32'd0);
      check("add_resp_alu_op", {29'd0, alu_op}, 32'd0);
      tick();
      check("add_back_idle", {31'd0, busy}, 32'd0);

      // Round-robin after a fresh reset, both requesters holding NOP
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 3'd0; req1_op = 3'd0;
      #1;
      check("rr1_ready0", {31'd0, req0_ready}, 32'd1);
      check("rr1_ready1", {31'd0, req1_ready}, 32'd0);
      tick(); tick();
      check("rr1_id", {31'd0, rsp_id}, 32'd0);
      tick();
      check("rr2_ready1", {31'd0, req1_ready}, 32'd1);
      check("rr2_ready0", {31'd0, req0_ready}, 32'd0);
      tick(); tick();
      check("rr2_id", {31'd0, rsp_id}, 32'd1);
      tick();
      check("rr3_ready0", {31'd0, req0_ready}, 32'd1);
      tick(); tick();
      check("rr3_id", {31'd0, rsp_id}, 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

      // DIV by zero from requester 1 with a stalled consumer
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'h3F800000; req1_b = 32'd0;
      #1;
      check("div_ready1", {31'd0, req1_ready}, 32'd1);
      tick(); req1_valid = 1'b0; req0_valid = 1'b1; req0_op = 3'd5;
      req0_a = 32'h12345678; req0_b = 32'h0; #1;
      check("div_exec_ready0", {31'd0, req0_ready}, 32'd0);
      repeat (7) tick();
      check("div_exec8_valid", {31'd0, rsp_valid}, 32'd0);
      check("div_exec8_op", {29'd0, alu_op}, 32'd4);
      tick();
      check("div_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("div_rsp_result", rsp_result, 32'h3F800004);
      check("div_rsp_flags", {26'd0, rsp_flags}, 32'h20);
      check("div_rsp_id", {31'd0, rsp_id}, 32'd1);
      check("div_sticky", {26'd0, sticky_flags}, 32'h20);
      held_res = 32'h3F800004;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("div_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("div_hold_result", rsp_result, held_res);
         check("div_hold_ready0", {31'd0, req0_ready}, 32'd0);
         check("div_hold_ready1", {31'd0, req1_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      // Requester 0 waited through the DIV; it is granted now, exactly once
      check("held_req0_granted", {31'd0, req0_ready}, 32'd1);
      tick(); req0_valid = 1'b0; clr_flags = 1'b1; #1;
      check("rnd_exec_op", {29'd0, alu_op}, 32'd5);
      tick(); clr_flags = 1'b0; #1;
      check("clr_capture_sticky", {26'd0, sticky_flags}, 32'h04);
      check("rnd_rsp_flags", {26'd0, rsp_flags}, 32'h04);
      check("rnd_rsp_id", {31'd0, rsp_id}, 32'd0);
      tick();
      check("no_dup_grant", {31'd0, busy}, 32'd0);
      clr_flags = 1'b1; tick(); clr_flags = 1'b0; #1;
      check("clr_alone", {26'd0, sticky_flags}, 32'd0);

      // Reset on the 4th EXEC cycle of a DIV
      req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'h40000000; req1_b = 32'd0;
      tick(); req1_valid = 1'b0;
      tick(); tick(); tick();
      check("div4_in_exec", {29'd0, alu_op}, 32'd4);
      rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
      check("rstx_busy", {31'd0, busy}, 32'd0);
      check("rstx_alu_op", {29'd0, alu_op}, 32'd0);
      check("rstx_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) seen++;
         end
         check("rstx_no_response", seen, 32'd0);
      end

      // ADD_LAT=0 instance: single EXEC cycle
      z_req0_valid = 1'b1; z_req0_op = 3'd1; z_req0_a = 32'h3F800000; z_req0_b = 32'h40000000;
      #1;
      check("z_ready0", {31'd0, z_req0_ready}, 32'd1);
      tick(); z_req0_valid = 1'b0; #1;
      check("z_exec_op", {29'd0, z_alu_op}, 32'd1);
      check("z_exec_valid", {31'd0, z_rsp_valid}, 32'd0);
      tick();
      check("z_rsp_valid", {31'd0, z_rsp_valid}, 32'd1);
      check("z_rsp_result", z_rsp_result, 32'h40400000);
      check("z_rsp_alu_op", {29'd0, z_alu_op}, 32'd0);
      tick();
      check("z_idle", {31'd0, z_busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
